// File: rtl/frame_dump_arbiter.sv
// Round-robin arbiter that shares the 256-word PC readout buffer
// between NREQ frame sources using the PC toggle handshake.
module frame_dump_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [32*NREQ-1:0]     src_data,
  output logic [NREQ-1:0]        grant,
  output logic [NREQ-1:0]        done,
  input  logic                   handshakePC,
  output logic                   handshakeFPGA,
  output logic                   we,
  output logic [7:0]             address,
  output logic [31:0]            data,
  output logic [23:0]            framecount,
  output logic                   busy
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_HDR  = 3'd2;
  localparam logic [2:0] S_DUMP = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};
  localparam logic [2:0] LAST_RST = 3'(NREQ - 1);

  logic [2:0]      state;
  logic [2:0]      nstate;
  logic [2:0]      sel;
  logic [2:0]      last;
  logic [2:0]      pick;
  logic [7:0]      addr;
  logic            hs;
  logic [23:0]     fcnt;
  logic            any_req;
  logic            sel_req;
  logic [NREQ-1:0] sel_oh;
  logic [31:0]     src_word;

  function automatic logic [2:0] rot(input logic [2:0] b, input int o);
    int t;
    t = (int'(b) + o) % NREQ;
    return t[2:0];
  endfunction

  // Descending scan so the smallest offset from last+1 wins;
  // offset NREQ is last itself, the lowest priority.
  always_comb begin
    pick = '0;
    for (int i = NREQ; i >= 1; i--) begin
      if (|(req & (ONE << rot(last, i))))
        pick = rot(last, i);
    end
  end

  assign any_req = |req;
  assign sel_oh  = ONE << sel;
  assign sel_req = |(req & sel_oh);

  always_comb begin
    src_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel == 3'(i))
        src_word = src_data[32*i +: 32];
    end
  end

  always_comb begin
    nstate = state;
    case (state)
      S_IDLE: begin
        if (any_req)
          nstate = S_WAIT;
      end
      S_WAIT: begin
        if (!sel_req)
          nstate = S_IDLE;
        else if (handshakePC == hs)
          nstate = S_HDR;
      end
      S_HDR:  nstate = S_DUMP;
      S_DUMP: begin
        if (addr == 8'hFF)
          nstate = S_DONE;
      end
      S_DONE: nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      sel   <= '0;
      last  <= LAST_RST;
      addr  <= '0;
      hs    <= 1'b0;
      fcnt  <= '0;
    end else begin
      state <= nstate;
      if (state == S_IDLE && any_req)
        sel <= pick;
      if (state == S_HDR)
        addr <= 8'd1;
      else if (state == S_DUMP && addr != 8'hFF)
        addr <= addr + 8'd1;
      else
        addr <= '0;
      if (state == S_DONE) begin
        hs   <= ~hs;
        fcnt <= fcnt + 24'd1;
        last <= sel;
      end
    end
  end

  always_comb begin
    we    = 1'b0;
    grant = '0;
    done  = '0;
    data  = '0;
    case (state)
      S_HDR: begin
        we   = 1'b1;
        data = {5'b0, sel, fcnt};
      end
      S_DUMP: begin
        we    = 1'b1;
        grant = sel_oh;
        data  = src_word;
      end
      S_DONE: done = sel_oh;
      default: ;
    endcase
  end

  assign busy          = (state != S_IDLE);
  assign address       = addr;
  assign handshakeFPGA = hs;
  assign framecount    = fcnt;

endmodule
